// File: rtl/dshot_rx.sv
`default_nettype none
// ============================================================================
// Module   : dshot_rx
// Brief    : DShot frame decoder (pulse-width bit slicer, 16-bit frame, CRC).
//            Define DSHOT_RX_BIDIR_EN for inverted-line bidirectional DShot.
// Revision : 1.0 - initial release
// ============================================================================
module dshot_rx #(
  parameter int BASE_FREQ  = 16_000_000,
  parameter int DSHOT_RATE = 600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dshot_in,
  output logic [10:0] throttle,
  output logic        telem_req,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        frame_err
);

  localparam int BIT_CLKS  = BASE_FREQ / (DSHOT_RATE * 1000);
  localparam int THRESH    = BIT_CLKS * 9 / 16;
  localparam int MIN_PULSE = BIT_CLKS / 8;
  localparam int GAP_CLKS  = 2 * BIT_CLKS;

  localparam logic [7:0] c_bit_clks  = 8'(BIT_CLKS);
  localparam logic [7:0] c_thresh    = 8'(THRESH);
  localparam logic [7:0] c_min_pulse = 8'(MIN_PULSE);
  localparam logic [7:0] c_gap_clks  = 8'(GAP_CLKS);

`ifdef DSHOT_RX_BIDIR_EN
  localparam logic c_line_idle = 1'b1;
`else
  localparam logic c_line_idle = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HIGH   = 3'd1,
    ST_LOW    = 3'd2,
    ST_CHECK  = 3'd3,
    ST_WAITLO = 3'd4
  } state_t;

  state_t       r_state, w_state_n;
  logic [1:0]   r_sync;
  logic         r_s_prev;
  logic [7:0]   r_hi_cnt, w_hi_cnt_n;
  logic [7:0]   r_lo_cnt, w_lo_cnt_n;
  logic [4:0]   r_bit_cnt, w_bit_cnt_n;
  logic [15:0]  r_sr, w_sr_n;
  logic [10:0]  w_throttle_n;
  logic         w_telem_n;
  logic         w_fv_n, w_ce_n, w_fe_n;
  logic         w_s, w_rise, w_fall;
  logic [11:0]  w_v;
  logic [3:0]   w_crc, w_crc_exp;

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= {2{c_line_idle}};
      r_s_prev <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], dshot_in};
      r_s_prev <= w_s;
    end
  end

`ifdef DSHOT_RX_BIDIR_EN
  assign w_s = ~r_sync[1];
`else
  assign w_s = r_sync[1];
`endif

  assign w_rise = w_s & ~r_s_prev;
  assign w_fall = ~w_s & r_s_prev;

  assign w_v   = r_sr[15:4];
  assign w_crc = w_v[3:0] ^ w_v[7:4] ^ w_v[11:8];
`ifdef DSHOT_RX_BIDIR_EN
  assign w_crc_exp = ~w_crc;
`else
  assign w_crc_exp = w_crc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hi_cnt    <= 8'd0;
      r_lo_cnt    <= 8'd0;
      r_bit_cnt   <= 5'd0;
      r_sr        <= 16'd0;
      throttle    <= 11'd0;
      telem_req   <= 1'b0;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_hi_cnt    <= w_hi_cnt_n;
      r_lo_cnt    <= w_lo_cnt_n;
      r_bit_cnt   <= w_bit_cnt_n;
      r_sr        <= w_sr_n;
      throttle    <= w_throttle_n;
      telem_req   <= w_telem_n;
      frame_valid <= w_fv_n;
      crc_err     <= w_ce_n;
      frame_err   <= w_fe_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_hi_cnt_n   = r_hi_cnt;
    w_lo_cnt_n   = r_lo_cnt;
    w_bit_cnt_n  = r_bit_cnt;
    w_sr_n       = r_sr;
    w_throttle_n = throttle;
    w_telem_n    = telem_req;
    w_fv_n       = 1'b0;
    w_ce_n       = 1'b0;
    w_fe_n       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_n   = ST_HIGH;
          w_hi_cnt_n  = 8'd1;
          w_bit_cnt_n = 5'd0;
        end
      end
      ST_HIGH: begin
        w_hi_cnt_n = sat_inc(r_hi_cnt);
        // Stuck-high takes priority over a coincident falling edge.
        if (r_hi_cnt > c_bit_clks) begin
          w_fe_n    = 1'b1;
          w_state_n = ST_WAITLO;
        end else if (w_fall) begin
          if (r_hi_cnt < c_min_pulse) begin
            w_fe_n    = 1'b1;
            w_state_n = ST_IDLE;
          end else begin
            w_sr_n      = {r_sr[14:0], (r_hi_cnt >= c_thresh)};
            w_bit_cnt_n = r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd15) begin
              w_state_n = ST_CHECK;
            end else begin
              w_state_n  = ST_LOW;
              w_lo_cnt_n = 8'd1;
            end
          end
        end
      end
      ST_LOW: begin
        w_lo_cnt_n = sat_inc(r_lo_cnt);
        if (w_rise) begin
          w_state_n  = ST_HIGH;
          w_hi_cnt_n = 8'd1;
        end else if (r_lo_cnt >= c_gap_clks) begin
          w_fe_n    = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (w_crc_exp == r_sr[3:0]) begin
          w_throttle_n = r_sr[15:5];
          w_telem_n    = r_sr[4];
          w_fv_n       = 1'b1;
        end else begin
          w_ce_n = 1'b1;
        end
        w_state_n = ST_IDLE;
      end
      ST_WAITLO: begin
        if (!w_s) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire
